rl_fifo_1r1w_ctrl: RTL and testbench
====================================

// Module: rl_fifo_1r1w_ctrl
// PURPOSE
//  Synchronous first-word-fall-through FIFO controller; the initiator side of an external rl_ram_1r1w.
//  Owns the write/read pointers, occupancy, flags and the RAM port sequencing.
//  Presents a push/pop FIFO interface to the client and drives the RAM write and read ports.
//  The RAM instance is built with RW_CONTENTION="BYPASS" and READ_*/WRITE_* equal to ABITS/DBITS.
// PARAMETERS
//  ABITS       4               RAM address bits; FIFO depth DEPTH = 2**ABITS entries
//  DBITS       32              data width
//  AFULL_LVL   2**ABITS-2      almost_full_o asserts when count_o >= AFULL_LVL
//  AEMPTY_LVL  1               almost_empty_o asserts when count_o <= AEMPTY_LVL
// PORTS
//  clk_i           in   1              clock, all logic on rising edge
//  rst_i           in   1              reset, synchronous, active-high
//  clr_i           in   1              synchronous flush, same effect as rst_i on FIFO state
//  push_i          in   1              write request
//  wdata_i         in   DBITS          write data
//  pop_i           in   1              read request, consumes rdata_o
//  rdata_o         out  DBITS          head-of-FIFO data, valid while !empty_o
//  empty_o         out  1              FIFO empty
//  full_o          out  1              FIFO full
//  almost_empty_o  out  1              count_o <= AEMPTY_LVL
//  almost_full_o   out  1              count_o >= AFULL_LVL
//  count_o         out  ABITS+1        occupancy, 0..DEPTH
//  overflow_o      out  1              1-cycle pulse: push_i while full_o
//  underflow_o     out  1              1-cycle pulse: pop_i while empty_o
//  ram_waddr_o     out  ABITS          RAM write address (= wptr)
//  ram_din_o       out  DBITS          RAM write data (= wdata_i)
//  ram_we_o        out  1              RAM write enable
//  ram_be_o        out  (DBITS+7)/8    RAM byte enables, constant all ones
//  ram_raddr_o     out  ABITS          RAM read address
//  ram_re_o        out  1              RAM read enable
//  ram_dout_i      in   DBITS          RAM read data, 1-cycle latency after ram_raddr_o
// BEHAVIOUR
//  Accept conditions:
//  - push_ok = push_i & !full_o; pop_ok = pop_i & !empty_o.
//  - full_o gates push_i even when pop_ok is true in the same cycle (no push-through when full).
//  Write side (combinational):
//  - ram_we_o = push_ok.
//  - wptr increments on push_ok and wraps DEPTH-1 -> 0.
//  Read side:
//  - rptr increments on pop_ok and wraps DEPTH-1 -> 0.
//  - ram_raddr_o = pop_ok ? rptr+1 (mod DEPTH) : rptr; ram_re_o = !rst_i.
//  - rdata_o = ram_dout_i, so the head word is read back every cycle.
//  - On a write to the address being read in the same cycle, the RAM bypass returns the new data.
//  Occupancy:
//  - count_o is +1 on push_ok only, -1 on pop_ok only, and unchanged on both or neither.
//  - Flags are registered and derived from the next-state count:
//    empty_o = (count==0), full_o = (count==DEPTH), plus the almost_* thresholds.
//  Latency:
//  - Push into an empty FIFO at edge N: empty_o falls at N+1 and rdata_o = that word in the same cycle.
//  - Pop at edge N: the next word is presented on rdata_o at N+1.
//  Error pulses:
//  - overflow_o and underflow_o are registered and high for exactly 1 cycle per offending request.
//  - The offending request is ignored; pointers and count are unchanged.
//  Reset (rst_i=1), checked before clr_i:
//  - wptr=rptr=0, count_o=0, empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0.
//  - overflow_o=underflow_o=0; ram_we_o=0 regardless of push_i.
//  - RAM contents are not cleared; rdata_o is undefined while empty_o=1.
//  clr_i:
//  - Same state as reset on the next edge.
//  - Any push or pop in the clr_i cycle is discarded, with no error pulse and ram_we_o=0.
//  - Reset or clr_i asserted mid-burst abandons all stored words.
// TESTING
//  - Reset, then idle -> empty_o=1, full_o=0, count_o=0, ram_we_o=0, no error pulses.
//  - ABITS=4: push 0x00..0x0F on 16 consecutive cycles
//    -> full_o=1 after the 16th edge, count_o=16, almost_full_o from count 14.
//    Then pop 16 times -> rdata_o sequence 0x00..0x0F, empty_o=1 at the end.
//  - Empty FIFO, push 0xA5A5A5A5 -> the next cycle shows empty_o=0 and rdata_o=0xA5A5A5A5 (bypass path).
//    Pop that cycle -> empty_o=1 the following cycle.
//  - Count 8, push+pop together for 40 cycles (pointers wrap) -> count_o stays 8, data order preserved.
//  - Full FIFO: push_i with pop_i=1 -> push rejected, overflow_o=1 for 1 cycle, count_o=15.
//    Empty FIFO: pop_i -> underflow_o=1 for 1 cycle, count_o stays 0.
//  - Count 5, assert clr_i together with push_i
//    -> next cycle count_o=0, empty_o=1, ram_we_o was 0.
//    Repeat the same with rst_i mid-burst -> same result.

Source files
------------

// File: rtl/rl_fifo_1r1w_ctrl.sv
// First-word-fall-through FIFO controller driving an external 1R1W RAM with write->read bypass.
// Owns pointers, occupancy, registered flags and error pulses; rdata_o is the RAM read port.
module rl_fifo_1r1w_ctrl #(
  parameter int ABITS      = 4,
  parameter int DBITS      = 32,
  parameter int AFULL_LVL  = 2**ABITS-2,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [DBITS-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [DBITS-1:0]       rdata_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic                   almost_empty_o,
  output logic                   almost_full_o,
  output logic [ABITS:0]         count_o,
  output logic                   overflow_o,
  output logic                   underflow_o,
  output logic [ABITS-1:0]       ram_waddr_o,
  output logic [DBITS-1:0]       ram_din_o,
  output logic                   ram_we_o,
  output logic [(DBITS+7)/8-1:0] ram_be_o,
  output logic [ABITS-1:0]       ram_raddr_o,
  output logic                   ram_re_o,
  input  logic [DBITS-1:0]       ram_dout_i
);

  localparam int DEPTH = 2**ABITS;
  localparam logic [ABITS:0] LP_DEPTH  = (ABITS+1)'(DEPTH);
  localparam logic [ABITS:0] LP_AFULL  = (ABITS+1)'(AFULL_LVL);
  localparam logic [ABITS:0] LP_AEMPTY = (ABITS+1)'(AEMPTY_LVL);

  logic [ABITS-1:0] r_wptr;
  logic [ABITS-1:0] r_rptr;
  logic [ABITS:0]   r_count;
  logic             r_empty;
  logic             r_full;
  logic             r_aempty;
  logic             r_afull;
  logic             r_ovf;
  logic             r_unf;

  logic             w_live;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [ABITS-1:0] w_rptr_inc;
  logic [ABITS:0]   w_count_nxt;

  // Reset and flush cycles swallow any request without side effects.
  assign w_live     = !rst_i && !clr_i;
  assign w_push_ok  = w_live && push_i && !r_full;
  assign w_pop_ok   = w_live && pop_i && !r_empty;
  assign w_rptr_inc = r_rptr + ABITS'(1);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_nxt = r_count + (ABITS+1)'(1);
    end else if (w_pop_ok && !w_push_ok) begin
      w_count_nxt = r_count - (ABITS+1)'(1);
    end
  end

  // Flags follow the next-state count so they line up with count_o after each edge.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_aempty <= 1'b1;
      r_afull  <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + ABITS'(1);
      end
      if (w_pop_ok) begin
        r_rptr <= w_rptr_inc;
      end
      r_count  <= w_count_nxt;
      r_empty  <= (w_count_nxt == '0);
      r_full   <= (w_count_nxt == LP_DEPTH);
      r_aempty <= (w_count_nxt <= LP_AEMPTY);
      r_afull  <= (w_count_nxt >= LP_AFULL);
      r_ovf    <= push_i && r_full;
      r_unf    <= pop_i && r_empty;
    end
  end

  // Reading rptr+1 on a pop keeps the next head word one cycle behind the pop.
  assign ram_raddr_o    = w_pop_ok ? w_rptr_inc : r_rptr;
  assign ram_re_o       = !rst_i;
  assign ram_waddr_o    = r_wptr;
  assign ram_din_o      = wdata_i;
  assign ram_we_o       = w_push_ok;
  assign ram_be_o       = '1;

  assign rdata_o        = ram_dout_i;
  assign empty_o        = r_empty;
  assign full_o         = r_full;
  assign almost_empty_o = r_aempty;
  assign almost_full_o  = r_afull;
  assign count_o        = r_count;
  assign overflow_o     = r_ovf;
  assign underflow_o    = r_unf;

endmodule

// File: tb/tb_rl_fifo_1r1w_ctrl.sv
// Bench for rl_fifo_1r1w_ctrl: behavioural bypass RAM, directed stimulus, scoreboard monitor on rdata_o.
module tb_rl_fifo_1r1w_ctrl;

  logic        clk;
  logic        rstIn;
  logic        clrIn;
  logic        pushIn;
  logic [31:0] wdataIn;
  logic        popIn;
  logic [31:0] rdata;
  logic        emptyOut;
  logic        fullOut;
  logic        aemptyOut;
  logic        afullOut;
  logic [4:0]  countOut;
  logic        ovfOut;
  logic        unfOut;
  logic [3:0]  ramWaddr;
  logic [31:0] ramDin;
  logic        ramWe;
  logic [3:0]  ramBe;
  logic [3:0]  ramRaddr;
  logic        ramRe;
  logic [31:0] ramDout;

  logic [31:0] mem [16];
  logic [31:0] sbQ [$];
  int          mCount;
  int          errors;
  int          checks;

  rl_fifo_1r1w_ctrl #(
    .ABITS(4), .DBITS(32), .AFULL_LVL(14), .AEMPTY_LVL(1)
  ) dut (
    .clk_i(clk), .rst_i(rstIn), .clr_i(clrIn),
    .push_i(pushIn), .wdata_i(wdataIn), .pop_i(popIn),
    .rdata_o(rdata), .empty_o(emptyOut), .full_o(fullOut),
    .almost_empty_o(aemptyOut), .almost_full_o(afullOut), .count_o(countOut),
    .overflow_o(ovfOut), .underflow_o(unfOut),
    .ram_waddr_o(ramWaddr), .ram_din_o(ramDin), .ram_we_o(ramWe), .ram_be_o(ramBe),
    .ram_raddr_o(ramRaddr), .ram_re_o(ramRe), .ram_dout_i(ramDout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External RAM: one-cycle read latency, same-address write returns the new word.
  always @(posedge clk) begin
    if (ramWe) mem[ramWaddr] <= ramDin;
    if (ramRe) ramDout <= (ramWe && ramWaddr == ramRaddr) ? ramDin : mem[ramRaddr];
  end

  // Whenever the head word is presented it must match the scoreboard front; a pop retires it.
  always @(negedge clk) begin
    if (!rstIn && !clrIn && emptyOut === 1'b0) begin
      checks++;
      if (sbQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL headData: rdata_o=%h shown but no word expected", rdata);
      end else if (rdata !== sbQ[0]) begin
        errors++;
        $display("[TB] FAIL headData: rdata_o=%h expected %h", rdata, sbQ[0]);
      end
      if (popIn && sbQ.size() > 0) void'(sbQ.pop_front());
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic setInputs(input logic p, input logic [31:0] d, input logic q, input logic c, input logic r);
    logic pushOk;
    logic popOk;
    pushIn  = p;
    wdataIn = d;
    popIn   = q;
    clrIn   = c;
    rstIn   = r;
    if (r || c) begin
      sbQ.delete();
      mCount = 0;
    end else begin
      pushOk = p && (mCount < 16);
      popOk  = q && (mCount > 0);
      if (pushOk) sbQ.push_back(d);
      mCount = mCount + int'(pushOk) - int'(popOk);
    end
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic p, input logic [31:0] d, input logic q, input logic c, input logic r);
    setInputs(p, d, q, c, r);
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    mCount = 0;
    setInputs(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    checkOutput("weInReset", 32'(ramWe), 32'd0);
    step();
    step();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("rstEmpty", 32'(emptyOut), 32'd1);
    checkOutput("rstFull", 32'(fullOut), 32'd0);
    checkOutput("rstCount", 32'(countOut), 32'd0);
    checkOutput("rstAempty", 32'(aemptyOut), 32'd1);
    checkOutput("rstAfull", 32'(afullOut), 32'd0);
    checkOutput("rstOvf", 32'(ovfOut), 32'd0);
    checkOutput("rstUnf", 32'(unfOut), 32'd0);
    checkOutput("idleWe", 32'(ramWe), 32'd0);
    checkOutput("byteEn", 32'(ramBe), 32'h0000_000F);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
      checkOutput("fillCount", 32'(countOut), 32'(i + 1));
      checkOutput("fillAfull", 32'(afullOut), (i + 1 >= 14) ? 32'd1 : 32'd0);
    end
    checkOutput("fillFull", 32'(fullOut), 32'd1);
    checkOutput("fillEmpty", 32'(emptyOut), 32'd0);
    checkOutput("fillAempty", 32'(aemptyOut), 32'd0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      checkOutput("drainCount", 32'(countOut), 32'(15 - i));
    end
    checkOutput("drainEmpty", 32'(emptyOut), 32'd1);
    checkOutput("drainFull", 32'(fullOut), 32'd0);
    checkOutput("drainAempty", 32'(aemptyOut), 32'd1);

    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("unfPulse", 32'(unfOut), 32'd1);
    checkOutput("unfCount", 32'(countOut), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("unfClear", 32'(unfOut), 32'd0);

    applyStimulus(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0);
    checkOutput("bypassEmpty", 32'(emptyOut), 32'd0);
    checkOutput("bypassData", rdata, 32'hA5A5_A5A5);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("bypassPopEmpty", 32'(emptyOut), 32'd1);

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0, 1'b0);
      checkOutput("steadyCount", 32'(countOut), 32'd8);
    end
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0, 1'b0);
    checkOutput("refillFull", 32'(fullOut), 32'd1);
    checkOutput("refillCount", 32'(countOut), 32'd16);

    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    checkOutput("ovfPulse", 32'(ovfOut), 32'd1);
    checkOutput("ovfCount", 32'(countOut), 32'd15);
    checkOutput("ovfFull", 32'(fullOut), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovfClear", 32'(ovfOut), 32'd0);
    checkOutput("ovfHold", 32'(countOut), 32'd15);

    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0, 1'b0);
    checkOutput("preClrCount", 32'(countOut), 32'd5);
    setInputs(1'b1, 32'h0BAD_0001, 1'b0, 1'b1, 1'b0);
    checkOutput("clrWe", 32'(ramWe), 32'd0);
    step();
    checkOutput("clrCount", 32'(countOut), 32'd0);
    checkOutput("clrEmpty", 32'(emptyOut), 32'd1);
    checkOutput("clrOvf", 32'(ovfOut), 32'd0);

    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0, 1'b0);
    setInputs(1'b1, 32'h0BAD_0002, 1'b1, 1'b0, 1'b1);
    checkOutput("rstWe", 32'(ramWe), 32'd0);
    step();
    checkOutput("midRstCount", 32'(countOut), 32'd0);
    checkOutput("midRstEmpty", 32'(emptyOut), 32'd1);
    checkOutput("midRstUnf", 32'(unfOut), 32'd0);

    applyStimulus(1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h601, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("resumeEmpty", 32'(emptyOut), 32'd1);
    checkOutput("sbDrained", 32'(sbQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
